disp_value_sequencer: RTL

Queues signed 8-bit results from the datapath and presents them one at a time to the four-digit decimal display stage. Each value is held for a programmable dwell time, followed by a short blank gap, so that consecutive equal values remain distinguishable. The block sits directly upstream of the decimal display driver and drives its `x` and `enable` inputs. Producers push values through a valid/ready handshake into a small FIFO.

---
 rtl/disp_value_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/disp_value_sequencer.sv
// disp_value_sequencer
//   Buffers signed 8-bit results in a small FIFO and presents them one at a
//   time to the decimal display stage: each value is shown for DWELL_CYCLES
//   with disp_en high, then blanked for GAP_CYCLES so that repeated equal
//   values remain distinguishable.
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_data    producer push (valid/ready), 8-bit two's complement
//   in_ready            FIFO not full (registered occupancy only)
//   hold                freezes the dwell countdown while a value is shown
//   clear               synchronous flush of FIFO and display state
//   x_out, disp_en      value and enable to the display driver
//   count               FIFO occupancy
module disp_value_sequencer #(
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int GAP_CYCLES   = 5_000_000,
   parameter int DEPTH        = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   input  logic                   hold,
   input  logic                   clear,
   output logic [7:0]             x_out,
   output logic                   disp_en,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW   = $clog2(DEPTH);
   localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   // ---------------- FIFO ----------------
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          push, pop, empty;

   // No lookahead: a pop in the same cycle never admits a push when full.
   assign in_ready = (count_q != (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign push     = in_valid && in_ready && !clear;
   assign count    = count_q;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (push && !pop)
         count_d = count_q + (AW+1)'(1);
      else if (pop && !push)
         count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // ---------------- display FSM ----------------
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    x_q, x_d;
   logic          en_q, en_d;

   assign x_out   = x_q;
   assign disp_en = en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         en_q    <= en_d;
      end
   end

   // Pops only look at registered occupancy, so a fresh push is never
   // bypassed straight to the display in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      en_d    = en_q;
      pop     = 1'b0;
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         x_d     = '0;
         en_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               en_d = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  x_d     = mem_q[rd_ptr_q];
                  en_d    = 1'b1;
                  cnt_d   = DWELL_LD;
                  state_d = SHOW;
               end
            end
            SHOW: begin
               if (!hold) begin
                  if (cnt_q == '0) begin
                     en_d    = 1'b0;
                     cnt_d   = GAP_LD;
                     state_d = GAP;
                  end else begin
                     cnt_d = cnt_q - CW'(1);
                  end
               end
            end
            GAP: begin
               // hold is deliberately ignored here; the gap length is fixed.
               if (cnt_q == '0) begin
                  if (!empty) begin
                     pop     = 1'b1;
                     x_d     = mem_q[rd_ptr_q];
                     en_d    = 1'b1;
                     cnt_d   = DWELL_LD;
                     state_d = SHOW;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               en_d    = 1'b0;
            end
         endcase
      end
   end

endmodule
